// File: rtl/lstm_delta_seq.sv
// LSTM backward-pass delta sequencer: computes the cell-state delta and the four gate
// deltas in saturating fixed point on one or two shared multipliers.
module lstm_delta_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned FRAC  = 24,
    parameter int unsigned NMUL  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] at,
    input  logic signed [WIDTH-1:0] it,
    input  logic signed [WIDTH-1:0] ft,
    input  logic signed [WIDTH-1:0] ot,
    input  logic signed [WIDTH-1:0] tanh_s,
    input  logic signed [WIDTH-1:0] c_prev,
    input  logic signed [WIDTH-1:0] d_h,
    input  logic signed [WIDTH-1:0] d_state_next,
    input  logic signed [WIDTH-1:0] f_next,
    input  logic                    last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] d_state,
    output logic signed [WIDTH-1:0] d_a,
    output logic signed [WIDTH-1:0] d_i,
    output logic signed [WIDTH-1:0] d_f,
    output logic signed [WIDTH-1:0] d_o,
    output logic                    sat,
    output logic                    busy
);

    localparam int unsigned NOPS  = 16;
    localparam int unsigned STEPS = NOPS / NMUL;
    localparam int unsigned CW    = 4;
    localparam logic signed [WIDTH-1:0] ONE  = WIDTH'(1) << FRAC;
    localparam logic signed [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

    typedef struct packed {
        logic                    s;
        logic signed [WIDTH-1:0] v;
    } res_t;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    // Full-width product, floor-shifted by FRAC, clamped to the data range.
    function automatic res_t sat_mul(input logic signed [WIDTH-1:0] a,
                                     input logic signed [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] p;
        logic signed [2*WIDTH-1:0] q;
        res_t r;
        p = (2*WIDTH)'(a) * (2*WIDTH)'(b);
        q = p >>> FRAC;
        r.s = 1'b0;
        r.v = q[WIDTH-1:0];
        if (q > (2*WIDTH)'(MAXV)) begin
            r.s = 1'b1;
            r.v = MAXV;
        end else if (q < (2*WIDTH)'(MINV)) begin
            r.s = 1'b1;
            r.v = MINV;
        end
        return r;
    endfunction

    function automatic res_t sat_addsub(input logic signed [WIDTH-1:0] a,
                                        input logic signed [WIDTH-1:0] b,
                                        input logic                    sub);
        logic signed [WIDTH:0] s;
        res_t r;
        s = sub ? ((WIDTH+1)'(a) - (WIDTH+1)'(b)) : ((WIDTH+1)'(a) + (WIDTH+1)'(b));
        r.s = 1'b0;
        r.v = s[WIDTH-1:0];
        if (s[WIDTH] != s[WIDTH-1]) begin
            r.s = 1'b1;
            r.v = s[WIDTH] ? MINV : MAXV;
        end
        return r;
    endfunction

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic            wb, wb_nx;
    logic            out_valid_nx, in_ready_nx, busy_nx;
    logic            acc_c, calc_c, wb_c;

    logic signed [WIDTH-1:0] at_r, it_r, ft_r, ot_r, ts_r, cp_r, dh_r, dsn_r, fn_r;
    logic                    last_r;
    logic signed [WIDTH-1:0] prod_r [NOPS];

    res_t            g_c, oma_c, omi_c, omf_c, omo_c, ds_c;
    logic [CW-1:0]   op_idx [2];
    logic signed [WIDTH-1:0] mul_a [2];
    logic signed [WIDTH-1:0] mul_b [2];
    res_t            mres [2];
    logic            step_sat_c, addsub_sat_c;

    assign acc_c  = (state == S_IDLE) && in_valid;
    assign calc_c = (state == S_CALC) && !wb;
    assign wb_c   = (state == S_CALC) && wb;

    // Add/sub terms, all formed from registered operands and earlier products.
    always_comb begin
        g_c   = sat_addsub(ONE, prod_r[0], 1'b1);
        oma_c = sat_addsub(ONE, prod_r[4], 1'b1);
        omi_c = sat_addsub(ONE, it_r, 1'b1);
        omf_c = sat_addsub(ONE, ft_r, 1'b1);
        omo_c = sat_addsub(ONE, ot_r, 1'b1);
        ds_c  = sat_addsub(prod_r[2], last_r ? '0 : prod_r[3], 1'b0);
        addsub_sat_c = g_c.s | oma_c.s | omi_c.s | omf_c.s | omo_c.s | ds_c.s;
    end

    // Multiply schedule: lane l of step cnt issues op cnt*NMUL+l; every op only
    // depends on products finished in an earlier step.
    always_comb begin
        step_sat_c = 1'b0;
        for (int unsigned l = 0; l < 2; l++) begin
            op_idx[l] = CW'(cnt * NMUL + l);
            mul_a[l]  = '0;
            mul_b[l]  = '0;
            case (op_idx[l])
                4'd0:  begin mul_a[l] = ts_r;       mul_b[l] = ts_r;       end
                4'd1:  begin mul_a[l] = dh_r;       mul_b[l] = ot_r;       end
                4'd2:  begin mul_a[l] = prod_r[1];  mul_b[l] = g_c.v;      end
                4'd3:  begin mul_a[l] = dsn_r;      mul_b[l] = fn_r;       end
                4'd4:  begin mul_a[l] = at_r;       mul_b[l] = at_r;       end
                4'd5:  begin mul_a[l] = it_r;       mul_b[l] = omi_c.v;    end
                4'd6:  begin mul_a[l] = ft_r;       mul_b[l] = omf_c.v;    end
                4'd7:  begin mul_a[l] = ot_r;       mul_b[l] = omo_c.v;    end
                4'd8:  begin mul_a[l] = dh_r;       mul_b[l] = ts_r;       end
                4'd9:  begin mul_a[l] = ds_c.v;     mul_b[l] = it_r;       end
                4'd10: begin mul_a[l] = ds_c.v;     mul_b[l] = at_r;       end
                4'd11: begin mul_a[l] = ds_c.v;     mul_b[l] = cp_r;       end
                4'd12: begin mul_a[l] = prod_r[9];  mul_b[l] = oma_c.v;    end
                4'd13: begin mul_a[l] = prod_r[10]; mul_b[l] = prod_r[5];  end
                4'd14: begin mul_a[l] = prod_r[11]; mul_b[l] = prod_r[6];  end
                4'd15: begin mul_a[l] = prod_r[8];  mul_b[l] = prod_r[7];  end
                default: ;
            endcase
            mres[l] = sat_mul(mul_a[l], mul_b[l]);
            // The recurrent product does not exist on the final timestep.
            if (l < NMUL && !(op_idx[l] == CW'(3) && last_r))
                step_sat_c = step_sat_c | mres[l].s;
        end
    end

    // Next-state logic; CALC ends with one writeback cycle after the last step.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        wb_nx    = wb;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    state_nx = S_CALC;
                    cnt_nx   = '0;
                    wb_nx    = 1'b0;
                end
            end
            S_CALC: begin
                if (wb) begin
                    state_nx = S_DONE;
                    wb_nx    = 1'b0;
                end else if (cnt == CW'(STEPS - 1)) begin
                    wb_nx  = 1'b1;
                    cnt_nx = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            S_DONE: begin
                if (out_ready)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        out_valid_nx = (state_nx == S_DONE);
        in_ready_nx  = (state_nx == S_IDLE);
        busy_nx      = (state_nx != S_IDLE);
    end

    // Control and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            wb        <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            sat       <= 1'b0;
            d_state   <= '0;
            d_a       <= '0;
            d_i       <= '0;
            d_f       <= '0;
            d_o       <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            wb        <= wb_nx;
            out_valid <= out_valid_nx;
            in_ready  <= in_ready_nx;
            busy      <= busy_nx;
            if (acc_c)
                sat <= 1'b0;
            else if (calc_c)
                sat <= sat | step_sat_c;
            else if (wb_c)
                sat <= sat | addsub_sat_c;
            if (wb_c) begin
                d_state <= ds_c.v;
                d_a     <= prod_r[12];
                d_i     <= prod_r[13];
                d_f     <= prod_r[14];
                d_o     <= prod_r[15];
            end
        end
    end

    // Operand capture and product storage.
    always_ff @(posedge clk) begin
        if (acc_c) begin
            at_r   <= at;
            it_r   <= it;
            ft_r   <= ft;
            ot_r   <= ot;
            ts_r   <= tanh_s;
            cp_r   <= c_prev;
            dh_r   <= d_h;
            dsn_r  <= d_state_next;
            fn_r   <= f_next;
            last_r <= last;
        end
        if (calc_c) begin
            for (int unsigned l = 0; l < NMUL; l++)
                prod_r[op_idx[l]] <= mres[l].v;
        end
    end

endmodule

// File: tb/tb_lstm_delta_seq.sv
// Bench for lstm_delta_seq: NMUL=1 and NMUL=2 instances run side by side against an
// arithmetic reference model of the delta equations.
module tb_lstm_delta_seq;

    localparam longint ONE  = 64'sd16777216;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, out_ready, last;
    logic signed [31:0] at, it, ft, ot, tanh_s, c_prev, d_h, d_state_next, f_next;
    logic in_ready_o [2];
    logic out_valid_o [2];
    logic sat_o [2];
    logic busy_o [2];
    logic signed [31:0] ds_o [2];
    logic signed [31:0] da_o [2];
    logic signed [31:0] di_o [2];
    logic signed [31:0] df_o [2];
    logic signed [31:0] do_o [2];

    int checks = 0;
    int errors = 0;
    longint e_ds, e_da, e_di, e_df, e_do;
    bit e_sat;
    bit msat;

    always #5 clk = ~clk;

    lstm_delta_seq #(.WIDTH(32), .FRAC(24), .NMUL(1)) u_m1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_o[0]),
        .at(at), .it(it), .ft(ft), .ot(ot), .tanh_s(tanh_s), .c_prev(c_prev),
        .d_h(d_h), .d_state_next(d_state_next), .f_next(f_next), .last(last),
        .out_valid(out_valid_o[0]), .out_ready(out_ready),
        .d_state(ds_o[0]), .d_a(da_o[0]), .d_i(di_o[0]), .d_f(df_o[0]), .d_o(do_o[0]),
        .sat(sat_o[0]), .busy(busy_o[0])
    );

    lstm_delta_seq #(.WIDTH(32), .FRAC(24), .NMUL(2)) u_m2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_o[1]),
        .at(at), .it(it), .ft(ft), .ot(ot), .tanh_s(tanh_s), .c_prev(c_prev),
        .d_h(d_h), .d_state_next(d_state_next), .f_next(f_next), .last(last),
        .out_valid(out_valid_o[1]), .out_ready(out_ready),
        .d_state(ds_o[1]), .d_a(da_o[1]), .d_i(di_o[1]), .d_f(df_o[1]), .d_o(do_o[1]),
        .sat(sat_o[1]), .busy(busy_o[1])
    );

    task automatic check(input string tag, input int u, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s nmul%0d observed %0d expected %0d", tag, u + 1, obs, exp);
        end
    endtask

    function automatic longint clamp(input longint v);
        if (v > MAXV) begin msat = 1'b1; return MAXV; end
        if (v < MINV) begin msat = 1'b1; return MINV; end
        return v;
    endfunction

    function automatic longint mq(input longint x, input longint y);
        return clamp((x * y) >>> 24);
    endfunction

    function automatic longint sadd(input longint a, input longint b);
        return clamp(a + b);
    endfunction

    function automatic longint ssub(input longint a, input longint b);
        return clamp(a - b);
    endfunction

    // Reference model: the delta equations evaluated directly in wide integers.
    task automatic model();
        longint xa, xi, xf, xo, xt, xc, xh, xn, xfn, tt, g, rec, ds;
        xa = longint'(at);  xi = longint'(it);  xf = longint'(ft);
        xo = longint'(ot);  xt = longint'(tanh_s); xc = longint'(c_prev);
        xh = longint'(d_h); xn = longint'(d_state_next); xfn = longint'(f_next);
        msat = 1'b0;
        tt = mq(xt, xt);
        g  = ssub(ONE, tt);
        rec = 0;
        if (!last) rec = mq(xn, xfn);
        ds = sadd(mq(mq(xh, xo), g), rec);
        e_ds = ds;
        e_da = mq(mq(ds, xi), ssub(ONE, mq(xa, xa)));
        e_di = mq(mq(ds, xa), mq(xi, ssub(ONE, xi)));
        e_df = mq(mq(ds, xc), mq(xf, ssub(ONE, xf)));
        e_do = mq(mq(xh, xt), mq(xo, ssub(ONE, xo)));
        e_sat = msat;
    endtask

    function automatic int rv();
        if ($urandom_range(3) == 0) return int'($urandom);
        return int'($urandom_range(32'd67108864)) - 33554432;
    endfunction

    task automatic set_ops(input int a_, input int i_, input int f_, input int o_,
                           input int t_, input int c_, input int h_, input int n_,
                           input int fn_, input bit l_);
        at = a_; it = i_; ft = f_; ot = o_; tanh_s = t_; c_prev = c_;
        d_h = h_; d_state_next = n_; f_next = fn_; last = l_;
    endtask

    task automatic set_random();
        set_ops(rv(), rv(), rv(), rv(), rv(), rv(), rv(), rv(), rv(), 1'($urandom_range(1)));
    endtask

    task automatic check_results(input string tag, input int u);
        check({tag, "_d_state"}, u, longint'(ds_o[u]), e_ds);
        check({tag, "_d_a"},     u, longint'(da_o[u]), e_da);
        check({tag, "_d_i"},     u, longint'(di_o[u]), e_di);
        check({tag, "_d_f"},     u, longint'(df_o[u]), e_df);
        check({tag, "_d_o"},     u, longint'(do_o[u]), e_do);
        check({tag, "_sat"},     u, longint'(sat_o[u]), longint'(e_sat));
    endtask

    // One operation through both instances; operands are scrambled after accept.
    task automatic run_op(input bit ready_);
        bit got [2];
        int lat [2];
        got = '{1'b0, 1'b0};
        lat = '{0, 0};
        model();
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = ready_;
        for (int u = 0; u < 2; u++) check("in_ready_pre", u, longint'(in_ready_o[u]), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        set_random();
        for (int e = 1; e <= 40 && !(got[0] && got[1]); e++) begin
            @(posedge clk); #1;
            for (int u = 0; u < 2; u++) begin
                if (!got[u] && out_valid_o[u]) begin
                    got[u] = 1'b1;
                    lat[u] = e;
                    check_results("op", u);
                    check("done_in_ready", u, longint'(in_ready_o[u]), 0);
                    check("done_busy", u, longint'(busy_o[u]), 1);
                end
            end
        end
        for (int u = 0; u < 2; u++) begin
            check("completed", u, longint'(got[u]), 1);
            check("latency", u, longint'(lat[u]), (u == 0) ? 17 : 9);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        bit saw;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        set_ops(0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            check("rst_out_valid", u, longint'(out_valid_o[u]), 0);
            check("rst_in_ready", u, longint'(in_ready_o[u]), 1);
            check("rst_busy", u, longint'(busy_o[u]), 0);
            check("rst_sat", u, longint'(sat_o[u]), 0);
            check("rst_d_state", u, longint'(ds_o[u]), 0);
        end
        @(negedge clk); rst = 1'b0;

        // All-zero operands on the final timestep.
        set_ops(0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
        run_op(1'b1);
        for (int u = 0; u < 2; u++) check("zero_d_o", u, longint'(do_o[u]), 0);

        // Unit gradient path, no recurrence.
        set_ops(0, 32'h0100_0000, 0, 32'h0100_0000, 0, 0, 32'h0100_0000, 0, 0, 1'b1);
        run_op(1'b1);
        for (int u = 0; u < 2; u++) begin
            check("unit_d_state", u, longint'(ds_o[u]), ONE);
            check("unit_d_a", u, longint'(da_o[u]), ONE);
            check("unit_d_i", u, longint'(di_o[u]), 0);
        end

        // Same with the recurrent term contributing half.
        set_ops(0, 32'h0100_0000, 0, 32'h0100_0000, 0, 0, 32'h0100_0000,
                32'h0100_0000, 32'h0080_0000, 1'b0);
        run_op(1'b1);
        for (int u = 0; u < 2; u++) begin
            check("rec_d_state", u, longint'(ds_o[u]), 64'sh0180_0000);
            check("rec_d_a", u, longint'(da_o[u]), 64'sh0180_0000);
        end

        // Saturating product.
        set_ops(0, 0, 0, 32'h7FFF_FFFF, 0, 0, 32'h7FFF_FFFF, 0, 0, 1'b1);
        run_op(1'b1);
        for (int u = 0; u < 2; u++) begin
            check("satp_d_state", u, longint'(ds_o[u]), MAXV);
            check("satp_sat", u, longint'(sat_o[u]), 1);
        end

        repeat (24) begin
            set_random();
            run_op(1'b1);
        end

        // Back-pressure in DONE with in_valid held high.
        set_random();
        run_op(1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            set_random();
            @(posedge clk); #1;
            for (int u = 0; u < 2; u++) begin
                check("hold_out_valid", u, longint'(out_valid_o[u]), 1);
                check("hold_in_ready", u, longint'(in_ready_o[u]), 0);
                check_results("hold", u);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        for (int u = 0; u < 2; u++) begin
            check("rel_out_valid", u, longint'(out_valid_o[u]), 0);
            check("rel_in_ready", u, longint'(in_ready_o[u]), 1);
            check("rel_busy", u, longint'(busy_o[u]), 0);
            check("retain_d_state", u, longint'(ds_o[u]), e_ds);
            check("retain_d_a", u, longint'(da_o[u]), e_da);
        end

        // Reset in the middle of CALC aborts the operation.
        set_random();
        @(negedge clk); in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        for (int u = 0; u < 2; u++) begin
            check("abort_out_valid", u, longint'(out_valid_o[u]), 0);
            check("abort_in_ready", u, longint'(in_ready_o[u]), 1);
            check("abort_busy", u, longint'(busy_o[u]), 0);
            check("abort_d_state", u, longint'(ds_o[u]), 0);
            check("abort_d_o", u, longint'(do_o[u]), 0);
        end
        @(negedge clk); rst = 1'b0;
        saw = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid_o[0] || out_valid_o[1]) saw = 1'b1;
        end
        check("abort_no_out_valid", 0, longint'(saw), 0);
        set_random();
        run_op(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lstm_delta_seq.md
LSTM_DELTA_SEQ -- requirements
Module: lstm_delta_seq

Interface
Parameters:
REQ-001: WIDTH, default 32, signed two's-complement data width of every data port.
REQ-002: FRAC, default 24, fractional bits; ONE = 1<<FRAC.
REQ-003: NMUL, default 1, number of shared fixed-point multipliers, legal values 1 or 2.
Ports:
REQ-004: clk  in  1  rising-edge clock.
REQ-005: rst  in  1  reset, synchronous, active-high.
REQ-006: in_valid  in  1  operand set valid; in_ready  out  1  block can accept operands.
REQ-007: at, it, ft, ot  in  WIDTH  candidate/input/forget/output gate activations.
REQ-008: tanh_s  in  WIDTH  tanh(state); c_prev  in  WIDTH  previous cell state.
REQ-009: d_h  in  WIDTH  incoming output delta; d_state_next  in  WIDTH  state delta from t+1; f_next  in  WIDTH  forget gate at t+1.
REQ-010: last  in  1  final timestep; the recurrent state term is forced to zero.
REQ-011: out_valid  out  1  results valid; out_ready  in  1  consumer accepts results.
REQ-012: d_state, d_a, d_i, d_f, d_o  out  WIDTH  state delta and the four gate deltas.
REQ-013: sat  out  1  a saturation occurred in the current result set; busy  out  1  FSM not in IDLE.

Function
REQ-014: m(x,y) SHALL be the full 2*WIDTH signed product, arithmetic-shifted right by FRAC (truncation toward -inf), saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-015: Every add/sub SHALL saturate to the same range; no operation may wrap.
REQ-016: The block SHALL compute exactly, in this association order:
 - g = ONE - m(tanh_s,tanh_s)
 - d_state = m(m(d_h,ot),g) + (last ? 0 : m(d_state_next,f_next))
 - d_a = m(m(d_state,it), ONE - m(at,at))
 - d_i = m(m(d_state,at), m(it, ONE-it))
 - d_f = m(m(d_state,c_prev), m(ft, ONE-ft))
 - d_o = m(m(d_h,tanh_s), m(ot, ONE-ot))
REQ-017: Results SHALL be bit-identical for NMUL=1 and NMUL=2; the per-cycle multiply schedule is implementation-defined, but the 16 products above SHALL all use the shared multiplier(s).
REQ-018: FSM states: IDLE -> CALC -> DONE -> IDLE.
REQ-019: IDLE: in_ready=1; on in_valid&in_ready, register all operands and last, clear sat, go to CALC.
REQ-020: CALC: a step counter runs 0..16/NMUL-1, then the FSM goes to DONE.
REQ-021: Latency: out_valid SHALL rise exactly 16/NMUL+1 rising edges after the accept edge (17 for NMUL=1, 9 for NMUL=2).
REQ-022: DONE: out_valid=1; all outputs held stable until out_valid&out_ready; the FSM returns to IDLE on the next edge.
REQ-023: in_ready=0 in CALC and DONE; in_valid in those states SHALL be ignored, with no effect on state or outputs.
REQ-024: Input ports SHALL NOT be sampled after the accept edge; operand changes during CALC have no effect.
REQ-025: sat SHALL be set if any m() or add/sub in REQ-016 saturated, and SHALL be valid while out_valid=1.
REQ-026: busy = (state != IDLE).
REQ-027: Outputs SHALL retain the last accepted result set after return to IDLE, until the next DONE.

Reset
REQ-028: When rst=1 at an edge, state=IDLE, counter=0, and out_valid, sat, busy, d_state, d_a, d_i, d_f, d_o all become 0.
REQ-029: After the same reset edge, in_ready=1.
REQ-030: rst in CALC or DONE SHALL abort the operation, with no out_valid for it.
REQ-031: rst has priority over a simultaneous in_valid or out_ready.

Verification (FRAC=24, WIDTH=32, ONE=0x01000000)
REQ-032: All operands 0, last=1 -> out_valid at accept+17 (NMUL=1); all outputs 0, sat=0.
REQ-033: d_h=ONE, ot=ONE, it=ONE, tanh_s=0, at=0, last=1 -> d_state=ONE, d_a=ONE, d_i=0, d_f=0, d_o=0.
REQ-034: As REQ-033 with last=0, d_state_next=ONE, f_next=0x00800000 -> d_state=0x01800000, d_a=0x01800000.
REQ-035: d_h=ot=0x7FFFFFFF, tanh_s=0, last=1 -> d_state=0x7FFFFFFF, sat=1.
REQ-036: out_ready held 0 for 5 cycles in DONE, with in_valid=1 -> outputs stable, in_ready=0, no second accept; out_ready=1 -> IDLE next edge.
REQ-037: rst pulsed at CALC step 5 -> all outputs 0 and in_ready=1 next edge; a fresh operation then completes with correct latency. Repeat REQ-033 with NMUL=2 -> identical values, latency 9.
